// File: rtl/reg_file_ctrl_if.sv
// Command / status bundle between the keypad-side sequencer client and
// reg_file_ctrl. master: issues store/recall/scan pulses, reads the reg_file
// control outputs and status. slave: the sequencer itself.
// Signals: store_req, recall_req, recall_idx[2:0], scan_start, scan_stop (cmds)
//          address[ADDR_W-1:0], write_en, read_en, cur_idx[2:0], count[2:0],
//          full, empty, busy, cmd_err (reg_file control and status)
interface reg_file_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              store_req;
    logic              recall_req;
    logic [2:0]        recall_idx;
    logic              scan_start;
    logic              scan_stop;
    logic [ADDR_W-1:0] address;
    logic              write_en;
    logic              read_en;
    logic [2:0]        cur_idx;
    logic [2:0]        count;
    logic              full;
    logic              empty;
    logic              busy;
    logic              cmd_err;

    modport master (
        output store_req, recall_req, recall_idx, scan_start, scan_stop,
        input  address, write_en, read_en, cur_idx, count,
        input  full, empty, busy, cmd_err
    );

    modport slave (
        input  store_req, recall_req, recall_idx, scan_start, scan_stop,
        output address, write_en, read_en, cur_idx, count,
        output full, empty, busy, cmd_err
    );
endinterface

// File: rtl/reg_file_ctrl.sv
// Command sequencer for the DEPTH-entry octal register file: turns store /
// recall / scan pulses into reg_file address, write_en and read_en, tracks
// the write pointer and valid-entry count, and auto-steps slots in scan mode.
// Ports: clk, rst_n (synchronous, active low), bus (reg_file_ctrl_if.slave).
// Build option: define RFC_WRAP_EN to accept stores when full, overwriting
// the oldest slot; otherwise a store when full is rejected with cmd_err.
module reg_file_ctrl #(
    parameter int DEPTH  = 5,
    parameter int ADDR_W = 8,
    parameter int DWELL  = 50_000_000,
    parameter int DW_W   = 26
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_file_ctrl_if.slave  bus
);

`ifdef RFC_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [2:0]      CNT_FULL = 3'(DEPTH);
    localparam logic [2:0]      LAST_IDX = 3'(DEPTH - 1);
    localparam logic [DW_W-1:0] DW_LAST  = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SHOW,
        SCAN
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      wptr_q, wptr_d;
    logic [2:0]      count_q, count_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic            err_q, err_d;
    logic            wen_q, wen_d;
    logic            ren_q, ren_d;

    logic full_w;
    logic any_cmd;

    assign full_w  = (count_q == CNT_FULL);
    assign any_cmd = bus.store_req | bus.recall_req
                   | bus.scan_start | bus.scan_stop;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        dwell_d = dwell_q;
        err_d   = 1'b0;

        if (state_q == WRITE) begin
            // Write lasts one cycle; anything arriving now is dropped.
            err_d   = any_cmd;
            state_d = IDLE;
            wptr_d  = (wptr_q == LAST_IDX) ? 3'd0 : wptr_q + 3'd1;
            if (!full_w) begin
                count_d = count_q + 3'd1;
            end
        end else if (bus.store_req) begin
            if (full_w && !WRAP_EN) begin
                err_d = 1'b1;
            end else begin
                state_d = WRITE;
                idx_d   = wptr_q;
            end
        end else if (bus.recall_req) begin
            if (bus.recall_idx < count_q) begin
                state_d = SHOW;
                idx_d   = bus.recall_idx;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.scan_start) begin
            if (count_q == 3'd0) begin
                err_d = 1'b1;
            end else begin
                state_d = SCAN;
                idx_d   = 3'd0;
                dwell_d = '0;
            end
        end else if (bus.scan_stop) begin
            state_d = IDLE;
        end else if (state_q == SCAN) begin
            // Dwell only advances on cycles with no command pulse.
            if (dwell_q == DW_LAST) begin
                dwell_d = '0;
                idx_d   = (idx_q == count_q - 3'd1) ? 3'd0 : idx_q + 3'd1;
            end else begin
                dwell_d = dwell_q + DW_W'(1);
            end
        end

        wen_d = (state_d == WRITE);
        ren_d = (state_d == SHOW) || (state_d == SCAN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            dwell_q <= '0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            dwell_q <= dwell_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
        end
    end

    assign bus.address  = ADDR_W'(idx_q);
    assign bus.cur_idx  = idx_q;
    assign bus.count    = count_q;
    assign bus.write_en = wen_q;
    assign bus.busy     = wen_q;
    assign bus.read_en  = ren_q;
    assign bus.cmd_err  = err_q;
    assign bus.full     = full_w;
    assign bus.empty    = (count_q == 3'd0);

endmodule
